// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS main control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback using one shared ALU
// and one shared memory. Memory states wait on mem_ready, and a timeout guards each wait.
module mips_multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          ADDI_EN     = 1'b1,
  parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       regDst,
  output logic       MemToReg,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  // Keep the counter at least one bit wide so MEM_TIMEOUT=0 still elaborates.
  localparam int unsigned   CW     = (TO_W > 0) ? TO_W : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(MEM_TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBeq    = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12,
    StTrap   = 4'd13
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_op_q, mem_timeout_q;
  logic          wait_st, to_hit, bad_op;

  // Next-state decode, including the memory-wait timeout override.
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    to_hit  = 1'b0;
    wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBeq;
          OP_J:         state_d = StJump;
          OP_ADDI: begin
            if (ADDI_EN) begin
              state_d = StAddiEx;
            end else begin
              state_d = StTrap;
              bad_op  = 1'b1;
            end
          end
          default: begin
            state_d = StTrap;
            bad_op  = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBeq:    state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StIdle;
    endcase
    // A ready in the final allowed cycle still wins over the timeout.
    if ((MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == TO_MAX)) begin
      to_hit  = 1'b1;
      state_d = StTrap;
    end
  end

  // Wait counter: counts stalled memory cycles, saturates, clears on any state change.
  always_comb begin
    cnt_d = cnt_q;
    if ((MEM_TIMEOUT == 0) || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (wait_st && !mem_ready && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State, counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      illegal_op_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bad_op) illegal_op_q <= 1'b1;
      if (to_hit) mem_timeout_q <= 1'b1;
    end
  end

  // Datapath controls decoded from the current state; only handshake/zero bypass the register.
  always_comb begin
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    regDst     = 1'b0;
    MemToReg   = 1'b0;
    regWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StMemWb: begin
        regWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        regWrite   = 1'b1;
        regDst     = 1'b1;
        instr_done = 1'b1;
      end
      StBeq: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op  = illegal_op_q;
  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: default instance plus a
// MEM_TIMEOUT=4 / ADDI_EN=0 instance sharing the same stimulus.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic IorD, MemRead, MemWrite, IRWrite, regDst, MemToReg, regWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic PCWrite, instr_done, illegal_op, mem_timeout;
  logic [3:0] state_o;

  logic IorD2, MemRead2, MemWrite2, IRWrite2, regDst2, MemToReg2, regWrite2, ALUSrcA2;
  logic [1:0] ALUSrcB2, ALUOp2, PCSrc2;
  logic PCWrite2, instr_done2, illegal_op2, mem_timeout2;
  logic [3:0] state2;

  logic [15:0] ctrl, ctrl2;

  int total = 0;
  int bad = 0;

  localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAdr = 4'd3;
  localparam logic [3:0] SMemRd = 4'd4, SMemWb = 4'd5, SMemWr = 4'd6, SExec = 4'd7;
  localparam logic [3:0] SAluWb = 4'd8, SBeq = 4'd9, SAddiEx = 4'd10, SAddiWb = 4'd11;
  localparam logic [3:0] SJump = 4'd12, STrap = 4'd13;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  // Order: IorD MemRead MemWrite IRWrite regDst MemToReg regWrite ALUSrcA
  //        ALUSrcB ALUOp PCSrc PCWrite instr_done
  localparam logic [15:0] CFetchR = 16'b0_1_0_1_0_0_0_0_01_00_00_1_0;
  localparam logic [15:0] CFetch0 = 16'b0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [15:0] CDecode = 16'b0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [15:0] CMemAdr = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [15:0] CMemRd  = 16'b1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] CMemWb  = 16'b0_0_0_0_0_1_1_0_00_00_00_0_1;
  localparam logic [15:0] CMemWr0 = 16'b1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] CMemWr1 = 16'b1_0_1_0_0_0_0_0_00_00_00_0_1;
  localparam logic [15:0] CExec   = 16'b0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [15:0] CAluWb  = 16'b0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [15:0] CBeq1   = 16'b0_0_0_0_0_0_0_1_00_01_01_1_1;
  localparam logic [15:0] CBeq0   = 16'b0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [15:0] CAddiWb = 16'b0_0_0_0_0_0_1_0_00_00_00_0_1;
  localparam logic [15:0] CJump   = 16'b0_0_0_0_0_0_0_0_00_00_10_1_1;
  localparam logic [15:0] CNone   = 16'h0000;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic [15:0] ctrl;
  } vec_t;

  mips_multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .regDst(regDst), .MemToReg(MemToReg), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  mips_multicycle_controller #(.MEM_TIMEOUT(4), .ADDI_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .regDst(regDst2), .MemToReg(MemToReg2), .regWrite(regWrite2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .PCSrc(PCSrc2), .PCWrite(PCWrite2),
    .instr_done(instr_done2), .illegal_op(illegal_op2), .mem_timeout(mem_timeout2),
    .state_o(state2)
  );

  assign ctrl  = {IorD, MemRead, MemWrite, IRWrite, regDst, MemToReg, regWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCWrite, instr_done};
  assign ctrl2 = {IorD2, MemRead2, MemWrite2, IRWrite2, regDst2, MemToReg2, regWrite2,
                  ALUSrcA2, ALUSrcB2, ALUOp2, PCSrc2, PCWrite2, instr_done2};

  initial forever #5 clk = ~clk;

  // Leaves both DUTs in IDLE, just after a negedge, with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = OpR;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (state_o !== SIdle || ctrl !== CNone || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold st=%0d ctrl=%b ill=%b to=%b want 0/0/0/0", state_o, ctrl,
               illegal_op, mem_timeout);
    end
    total++;
    if (state2 !== SIdle || ctrl2 !== CNone || illegal_op2 !== 1'b0 || mem_timeout2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold2 st=%0d ctrl=%b want 0/0", state2, ctrl2);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (state_o !== SIdle || ctrl !== CNone) begin
      bad++;
      $display("FAIL reset_idle st=%0d ctrl=%b want st=0 ctrl=0", state_o, ctrl);
    end
    @(negedge clk);
    #1;
    total++;
    if (state_o !== SFetch || ctrl !== CFetchR) begin
      bad++;
      $display("FAIL reset_to_fetch st=%0d ctrl=%b want st=1 ctrl=%b", state_o, ctrl, CFetchR);
    end
  endtask

  task automatic test_rtype();
    vec_t v [5] = '{
      '{SFetch, OpR, 1'b1, 1'b0, CFetchR}, '{SDecode, OpR, 1'b1, 1'b0, CDecode},
      '{SExec, OpR, 1'b1, 1'b0, CExec}, '{SAluWb, OpR, 1'b1, 1'b0, CAluWb},
      '{SFetch, OpR, 1'b1, 1'b0, CFetchR}};
    int done_cnt = 0;
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      if (instr_done === 1'b1) done_cnt++;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL rtype step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL rtype_done_pulses got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_lw_wait();
    vec_t v [9] = '{
      '{SFetch, OpLw, 1'b1, 1'b0, CFetchR}, '{SDecode, OpLw, 1'b1, 1'b0, CDecode},
      '{SMemAdr, OpLw, 1'b1, 1'b0, CMemAdr}, '{SMemRd, OpLw, 1'b0, 1'b0, CMemRd},
      '{SMemRd, OpLw, 1'b0, 1'b0, CMemRd}, '{SMemRd, OpLw, 1'b0, 1'b0, CMemRd},
      '{SMemRd, OpLw, 1'b1, 1'b0, CMemRd}, '{SMemWb, OpLw, 1'b1, 1'b0, CMemWb},
      '{SFetch, OpLw, 1'b1, 1'b0, CFetchR}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL lw_wait step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
  endtask

  task automatic test_sw_wait();
    vec_t v [7] = '{
      '{SFetch, OpSw, 1'b1, 1'b0, CFetchR}, '{SDecode, OpSw, 1'b1, 1'b0, CDecode},
      '{SMemAdr, OpSw, 1'b1, 1'b0, CMemAdr}, '{SMemWr, OpSw, 1'b0, 1'b0, CMemWr0},
      '{SMemWr, OpSw, 1'b0, 1'b0, CMemWr0}, '{SMemWr, OpSw, 1'b1, 1'b0, CMemWr1},
      '{SFetch, OpSw, 1'b1, 1'b0, CFetchR}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL sw_wait step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
  endtask

  task automatic test_beq();
    vec_t v [7] = '{
      '{SFetch, OpBeq, 1'b1, 1'b0, CFetchR}, '{SDecode, OpBeq, 1'b1, 1'b0, CDecode},
      '{SBeq, OpBeq, 1'b1, 1'b1, CBeq1}, '{SFetch, OpBeq, 1'b1, 1'b0, CFetchR},
      '{SDecode, OpBeq, 1'b1, 1'b0, CDecode}, '{SBeq, OpBeq, 1'b1, 1'b0, CBeq0},
      '{SFetch, OpBeq, 1'b1, 1'b0, CFetchR}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL beq step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [12] = '{
      '{SFetch, OpJ, 1'b1, 1'b0, CFetchR}, '{SDecode, OpJ, 1'b1, 1'b0, CDecode},
      '{SJump, OpR, 1'b1, 1'b0, CJump}, '{SFetch, OpR, 1'b1, 1'b0, CFetchR},
      '{SDecode, OpR, 1'b1, 1'b0, CDecode}, '{SExec, OpR, 1'b1, 1'b0, CExec},
      '{SAluWb, OpAddi, 1'b1, 1'b0, CAluWb}, '{SFetch, OpAddi, 1'b1, 1'b0, CFetchR},
      '{SDecode, OpAddi, 1'b1, 1'b0, CDecode}, '{SAddiEx, OpAddi, 1'b1, 1'b0, CMemAdr},
      '{SAddiWb, OpAddi, 1'b1, 1'b0, CAddiWb}, '{SFetch, OpAddi, 1'b1, 1'b0, CFetchR}};
    int done_cnt = 0;
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      if (instr_done === 1'b1) done_cnt++;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL b2b step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (done_cnt !== 3) begin
      bad++;
      $display("FAIL b2b_done_pulses got=%0d want=3", done_cnt);
    end
  endtask

  task automatic test_illegal();
    vec_t v [2] = '{
      '{SFetch, OpBad, 1'b1, 1'b0, CFetchR}, '{SDecode, OpBad, 1'b1, 1'b0, CDecode}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL illegal step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL illegal_early got=%b want=0", illegal_op);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = i[0]; zero = ~i[0]; opcode = OpR;
      #1;
      total++;
      if (state_o !== STrap || ctrl !== CNone || illegal_op !== 1'b1 || mem_timeout !== 1'b0) begin
        bad++;
        $display("FAIL illegal_trap cyc%0d st=%0d ctrl=%b ill=%b to=%b want 13/0/1/0", i,
                 state_o, ctrl, illegal_op, mem_timeout);
      end
    end
  endtask

  task automatic test_addi_disabled();
    vec_t v [3] = '{
      '{SFetch, OpAddi, 1'b1, 1'b0, CFetchR}, '{SDecode, OpAddi, 1'b1, 1'b0, CDecode},
      '{STrap, OpAddi, 1'b1, 1'b0, CNone}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state2 !== v[i].st || ctrl2 !== v[i].ctrl) begin
        bad++;
        $display("FAIL addi_off step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state2, ctrl2,
                 v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (illegal_op2 !== 1'b1 || state_o !== SAddiEx || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL addi_off_flags ill2=%b st=%0d ill=%b want 1/10/0", illegal_op2, state_o,
               illegal_op);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = i[0]; zero = i[1];
      #1;
      total++;
      if (state2 !== STrap || ctrl2 !== CNone || illegal_op2 !== 1'b1) begin
        bad++;
        $display("FAIL addi_off_trap cyc%0d st=%0d ctrl=%b ill=%b want 13/0/1", i, state2,
                 ctrl2, illegal_op2);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t v [6] = '{
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{STrap, OpR, 1'b0, 1'b0, CNone}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state2 !== v[i].st || ctrl2 !== v[i].ctrl || (i == 4 && mem_timeout2 !== 1'b0)) begin
        bad++;
        $display("FAIL timeout step%0d st=%0d ctrl=%b to=%b want st=%0d ctrl=%b", i, state2,
                 ctrl2, mem_timeout2, v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (mem_timeout2 !== 1'b1 || illegal_op2 !== 1'b0 || mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flags to2=%b ill2=%b to=%b want 1/0/0", mem_timeout2, illegal_op2,
               mem_timeout);
    end
  endtask

  task automatic test_timeout_rescue();
    vec_t v [14] = '{
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b1, 1'b0, CFetchR}, '{SDecode, OpR, 1'b1, 1'b0, CDecode},
      '{SExec, OpR, 1'b1, 1'b0, CExec}, '{SAluWb, OpR, 1'b1, 1'b0, CAluWb},
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b0, 1'b0, CFetch0}, '{SFetch, OpR, 1'b0, 1'b0, CFetch0},
      '{SFetch, OpR, 1'b1, 1'b0, CFetchR}, '{SDecode, OpR, 1'b1, 1'b0, CDecode}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state2 !== v[i].st || ctrl2 !== v[i].ctrl) begin
        bad++;
        $display("FAIL rescue step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state2, ctrl2,
                 v[i].st, v[i].ctrl);
      end
    end
    total++;
    if (mem_timeout2 !== 1'b0) begin
      bad++;
      $display("FAIL rescue_flag to2=%b want 0", mem_timeout2);
    end
  endtask

  task automatic test_reset_midwrite();
    vec_t v [4] = '{
      '{SFetch, OpSw, 1'b1, 1'b0, CFetchR}, '{SDecode, OpSw, 1'b1, 1'b0, CDecode},
      '{SMemAdr, OpSw, 1'b1, 1'b0, CMemAdr}, '{SMemWr, OpSw, 1'b0, 1'b0, CMemWr0}};
    do_reset();
    foreach (v[i]) begin
      @(negedge clk);
      opcode = v[i].op; mem_ready = v[i].rdy; zero = v[i].z;
      #1;
      total++;
      if (state_o !== v[i].st || ctrl !== v[i].ctrl) begin
        bad++;
        $display("FAIL midwr step%0d st=%0d ctrl=%b want st=%0d ctrl=%b", i, state_o, ctrl,
                 v[i].st, v[i].ctrl);
      end
    end
    // Reset lands between clock edges; outputs must drop without a clock.
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (MemWrite !== 1'b0 || state_o !== SIdle || ctrl !== CNone) begin
      bad++;
      $display("FAIL midwr_async MemWrite=%b st=%0d ctrl=%b want 0/0/0", MemWrite, state_o, ctrl);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (state_o !== SFetch || ctrl !== CFetch0) begin
      bad++;
      $display("FAIL midwr_refetch st=%0d ctrl=%b want st=1 ctrl=%b", state_o, ctrl, CFetch0);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_addi_disabled();
    test_timeout();
    test_timeout_rescue();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
